// File: rtl/set_scan_ctrl_pkg.sv
// Shared types and helpers for the three-circle set-scan sequencer.
// Holds bus field widths, the job payload structs, the set-mode and
// FSM state encodings, plus the circle-coverage and match helpers.
package set_scan_ctrl_pkg;

  localparam int unsigned AXIS_W     = 4;
  localparam int unsigned COORD_SZ   = 2 * AXIS_W;
  localparam int unsigned CENTRAL_SZ = 6 * AXIS_W;
  localparam int unsigned RADIUS_SZ  = 3 * AXIS_W;
  localparam int unsigned COVERED_SZ = 3;
  localparam int unsigned MODE_SZ    = 2;
  localparam int unsigned SQ_W       = 10;

  typedef enum logic [MODE_SZ-1:0] {
    MODE_A   = 2'b00,
    MODE_AND = 2'b01,
    MODE_XOR = 2'b10,
    MODE_TWO = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // {x,y}: x in the upper nibble
  typedef struct packed {
    logic [AXIS_W-1:0] x;
    logic [AXIS_W-1:0] y;
  } coord_t;

  typedef struct packed {
    coord_t a;
    coord_t b;
    coord_t c;
  } central_t;

  typedef struct packed {
    logic [AXIS_W-1:0] a;
    logic [AXIS_W-1:0] b;
    logic [AXIS_W-1:0] c;
  } radius_t;

  // Inclusive coverage test r^2 >= dx^2 + dy^2 using absolute differences.
  function automatic logic in_circle(input coord_t p, input coord_t ctr,
                                     input logic [AXIS_W-1:0] r);
    logic [AXIS_W-1:0] dx;
    logic [AXIS_W-1:0] dy;
    logic [SQ_W-1:0]   d2;
    logic [SQ_W-1:0]   r2;
    dx = (p.x >= ctr.x) ? (p.x - ctr.x) : (ctr.x - p.x);
    dy = (p.y >= ctr.y) ? (p.y - ctr.y) : (ctr.y - p.y);
    d2 = SQ_W'(dx) * SQ_W'(dx) + SQ_W'(dy) * SQ_W'(dy);
    r2 = SQ_W'(r) * SQ_W'(r);
    return (r2 >= d2);
  endfunction

  // Set expression on the coverage vector {a,b,c}.
  function automatic logic set_match(input mode_e mode,
                                     input logic [COVERED_SZ-1:0] cov);
    logic a;
    logic b;
    logic c;
    logic m;
    a = cov[2];
    b = cov[1];
    c = cov[0];
    case (mode)
      MODE_A:   m = a;
      MODE_AND: m = a & b;
      MODE_XOR: m = a ^ b;
      MODE_TWO: m = (a & b & ~c) | (a & ~b & c) | (~a & b & c);
      default:  m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/set_scan_ctrl_pe.sv
// Coverage PE: reports which of circles A/B/C contain the given lattice point.
// Ports:
//   coord_i    {x,y} lattice point
//   central_i  {A_X,A_Y,B_X,B_Y,C_X,C_Y}
//   radius_i   {A_R,B_R,C_R}
//   covered_c  {a,b,c} coverage flags, combinational
module set_scan_ctrl_pe
  import set_scan_ctrl_pkg::*;
(
  input  logic [COORD_SZ-1:0]   coord_i,
  input  logic [CENTRAL_SZ-1:0] central_i,
  input  logic [RADIUS_SZ-1:0]  radius_i,
  output logic [COVERED_SZ-1:0] covered_c
);

  coord_t   pt;
  central_t ctr;
  radius_t  rad;

  assign pt  = coord_t'(coord_i);
  assign ctr = central_t'(central_i);
  assign rad = radius_t'(radius_i);

  assign covered_c = {in_circle(pt, ctr.a, rad.a),
                      in_circle(pt, ctr.b, rad.b),
                      in_circle(pt, ctr.c, rad.c)};

endmodule

// File: rtl/set_scan_ctrl.sv
// Set-scan sequencer: latches one job, sweeps the GRID_N x GRID_N lattice
// through a single PE one point per cycle, and counts points matching the
// selected set expression.
// Optional build macro: SET_PIPE_EN registers the PE output before the
// counter and inserts a DRAIN state so the last point is still counted.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   en_i           job request, sampled only in IDLE
//   central_i      {A_X,A_Y,B_X,B_Y,C_X,C_Y}
//   radius_i       {A_R,B_R,C_R}
//   mode_i         set expression select
//   busy_o         job in flight, through the valid_o cycle
//   valid_o        one-cycle pulse, candidate_o holds the final count
//   candidate_o    match count of the last completed job
module set_scan_ctrl
  import set_scan_ctrl_pkg::*;
#(
  parameter int unsigned GRID_N = 8,
  parameter int unsigned CNT_W  = 7
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic [CENTRAL_SZ-1:0] central_i,
  input  logic [RADIUS_SZ-1:0]  radius_i,
  input  logic [MODE_SZ-1:0]    mode_i,
  output logic                  busy_o,
  output logic                  valid_o,
  output logic [CNT_W-1:0]      candidate_o
);

  localparam logic [AXIS_W-1:0] LAST = AXIS_W'(GRID_N);
  localparam logic [AXIS_W-1:0] ONE  = AXIS_W'(1);

  state_e                  state_q;
  state_e                  state_d;
  logic [AXIS_W-1:0]       x_q;
  logic [AXIS_W-1:0]       y_q;
  logic [CENTRAL_SZ-1:0]   central_q;
  logic [RADIUS_SZ-1:0]    radius_q;
  mode_e                   mode_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [CNT_W-1:0]        cnt_next_c;
  logic [COVERED_SZ-1:0]   covered_c;
  logic                    accept_c;
  logic                    last_pt_c;
  logic                    inc_c;

  set_scan_ctrl_pe u_pe (
    .coord_i   ({x_q, y_q}),
    .central_i (central_q),
    .radius_i  (radius_q),
    .covered_c (covered_c)
  );

  assign accept_c  = (state_q == S_IDLE) && en_i;
  assign last_pt_c = (x_q == LAST) && (y_q == LAST);

`ifdef SET_PIPE_EN
  logic [COVERED_SZ-1:0] covered_q;
  logic                  match_vld_q;

  // One-stage pipe between PE and counter; flag marks a real scan point.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      covered_q   <= '0;
      match_vld_q <= 1'b0;
    end else begin
      covered_q   <= covered_c;
      match_vld_q <= (state_q == S_SCAN);
    end
  end

  assign inc_c = match_vld_q && set_match(mode_q, covered_q);
`else
  assign inc_c = (state_q == S_SCAN) && set_match(mode_q, covered_c);
`endif

  assign cnt_next_c = cnt_q + CNT_W'(inc_c);

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (en_i) state_d = S_SCAN;
      S_SCAN: begin
        if (last_pt_c) begin
`ifdef SET_PIPE_EN
          state_d = S_DRAIN;
`else
          state_d = S_DONE;
`endif
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Job buffers, raster coordinate and match counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      central_q <= '0;
      radius_q  <= '0;
      mode_q    <= MODE_A;
      x_q       <= ONE;
      y_q       <= ONE;
      cnt_q     <= '0;
    end else begin
      if (accept_c) begin
        central_q <= central_i;
        radius_q  <= radius_i;
        mode_q    <= mode_e'(mode_i);
        cnt_q     <= '0;
      end else begin
        cnt_q <= cnt_next_c;
      end
      if (state_q == S_SCAN) begin
        if (x_q == LAST) begin
          x_q <= ONE;
          y_q <= (y_q == LAST) ? ONE : y_q + ONE;
        end else begin
          x_q <= x_q + ONE;
        end
      end
    end
  end

  // Registered status outputs; count captured on entry to DONE
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_o      <= 1'b0;
      valid_o     <= 1'b0;
      candidate_o <= '0;
    end else begin
      busy_o  <= (state_d != S_IDLE);
      valid_o <= (state_d == S_DONE);
      if (state_d == S_DONE) candidate_o <= cnt_next_c;
    end
  end

endmodule

// File: tb/tb_set_scan_ctrl.sv
// Directed bench for set_scan_ctrl: result counts, valid_o latency,
// ignored requests, back-to-back jobs and mid-job reset.
module tb_set_scan_ctrl;
  import set_scan_ctrl_pkg::*;

`ifdef SET_PIPE_EN
  localparam int LAT = 66;
`else
  localparam int LAT = 65;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  en;
  logic [CENTRAL_SZ-1:0] central;
  logic [RADIUS_SZ-1:0]  radius;
  logic [MODE_SZ-1:0]    mode;
  logic                  busy;
  logic                  valid;
  logic [6:0]            candidate;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  set_scan_ctrl #(.GRID_N(8), .CNT_W(7)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .en_i        (en),
    .central_i   (central),
    .radius_i    (radius),
    .mode_i      (mode),
    .busy_o      (busy),
    .valid_o     (valid),
    .candidate_o (candidate)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] cen(input logic [3:0] ax, input logic [3:0] ay,
                                      input logic [3:0] bx, input logic [3:0] by,
                                      input logic [3:0] cx, input logic [3:0] cy);
    return {ax, ay, bx, by, cx, cy};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance until valid is seen or the cycle budget runs out.
  task automatic wait_valid(input int start, output int cyc);
    cyc = start;
    while (!valid && cyc < 200) begin
      step();
      cyc++;
    end
  endtask

  task automatic run_job(input string tag, input logic [23:0] c, input logic [11:0] r,
                         input logic [1:0] m, input int exp_cnt);
    int cyc;
    central = c;
    radius  = r;
    mode    = m;
    en      = 1'b1;
    step();
    en = 1'b0;
    check({tag, "_busy1"}, 32'(busy), 32'd1);
    wait_valid(1, cyc);
    check({tag, "_lat"}, 32'(cyc), 32'(LAT));
    check({tag, "_cnt"}, 32'(candidate), 32'(exp_cnt));
    step();
    check({tag, "_vld_low"}, 32'(valid), 32'd0);
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
    check({tag, "_hold"}, 32'(candidate), 32'(exp_cnt));
  endtask

  initial begin
    int cyc;
    int vcount;
    rst     = 1'b1;
    en      = 1'b0;
    central = '0;
    radius  = '0;
    mode    = 2'b00;
    step();
    step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_cand", 32'(candidate), 32'd0);
    rst = 1'b0;
    step();

    run_job("t1_a",      cen(4, 4, 0, 0, 0, 0), {4'd2, 4'd0, 4'd0}, 2'b00, 13);
    run_job("t2_and",    cen(4, 4, 4, 4, 0, 0), {4'd2, 4'd2, 4'd0}, 2'b01, 13);
    run_job("t2_xor",    cen(4, 4, 4, 4, 0, 0), {4'd2, 4'd2, 4'd0}, 2'b10, 0);
    run_job("t3_two",    cen(4, 4, 4, 4, 4, 4), {4'd2, 4'd2, 4'd0}, 2'b11, 12);
    run_job("t3_three",  cen(4, 4, 4, 4, 4, 4), {4'd2, 4'd2, 4'd2}, 2'b11, 0);
    run_job("t4_full",   cen(1, 1, 0, 0, 0, 0), {4'd15, 4'd0, 4'd0}, 2'b00, 64);
    run_job("t4_corner", cen(1, 1, 0, 0, 0, 0), {4'd0, 4'd0, 4'd0}, 2'b00, 1);
    run_job("off_r2",    cen(0, 0, 0, 0, 0, 0), {4'd2, 4'd0, 4'd0}, 2'b00, 1);
    run_job("off_r1",    cen(0, 0, 0, 0, 0, 0), {4'd1, 4'd0, 4'd0}, 2'b00, 0);
    run_job("xor_pt",    cen(4, 4, 5, 4, 0, 0), {4'd2, 4'd0, 4'd0}, 2'b10, 12);
    run_job("and_pt",    cen(4, 4, 5, 4, 0, 0), {4'd2, 4'd0, 4'd0}, 2'b01, 1);

    // Request pulsed mid-scan with a different job is ignored
    central = cen(4, 4, 0, 0, 0, 0);
    radius  = {4'd2, 4'd0, 4'd0};
    mode    = 2'b00;
    en      = 1'b1;
    step();
    en = 1'b0;
    repeat (9) step();
    central = cen(1, 1, 0, 0, 0, 0);
    radius  = {4'd15, 4'd0, 4'd0};
    en      = 1'b1;
    step();
    en = 1'b0;
    wait_valid(11, cyc);
    check("t5_ign_lat", 32'(cyc), 32'(LAT));
    check("t5_ign_cnt", 32'(candidate), 32'd13);
    step();
    check("t5_ign_idle", 32'(busy), 32'd0);
    step();
    check("t5_ign_nojob", 32'(busy), 32'd0);

    // en held high: back-to-back jobs with a one-cycle busy gap
    central = cen(4, 4, 0, 0, 0, 0);
    radius  = {4'd2, 4'd0, 4'd0};
    mode    = 2'b00;
    en      = 1'b1;
    step();
    central = cen(1, 1, 0, 0, 0, 0);
    radius  = {4'd15, 4'd0, 4'd0};
    wait_valid(1, cyc);
    check("t5_b2b_lat1", 32'(cyc), 32'(LAT));
    check("t5_b2b_cnt1", 32'(candidate), 32'd13);
    step();
    check("t5_b2b_gap", 32'(busy), 32'd0);
    check("t5_b2b_gapv", 32'(valid), 32'd0);
    step();
    en = 1'b0;
    check("t5_b2b_busy2", 32'(busy), 32'd1);
    wait_valid(1, cyc);
    check("t5_b2b_lat2", 32'(cyc), 32'(LAT));
    check("t5_b2b_cnt2", 32'(candidate), 32'd64);
    step();

    // Reset mid-scan aborts the job
    central = cen(4, 4, 0, 0, 0, 0);
    radius  = {4'd2, 4'd0, 4'd0};
    en      = 1'b1;
    step();
    en = 1'b0;
    repeat (19) step();
    rst = 1'b1;
    step();
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_cand", 32'(candidate), 32'd0);
    check("t6_valid", 32'(valid), 32'd0);
    rst    = 1'b0;
    vcount = 0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (valid) vcount++;
    end
    check("t6_no_valid", 32'(vcount), 32'd0);
    run_job("t6_after", cen(1, 1, 0, 0, 0, 0), {4'd15, 4'd0, 4'd0}, 2'b00, 64);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
